// File: rtl/pad_share_ctrl_if.sv
// Bus between the pad-sharing controller and its surroundings: serial config
// pads, candidate core sources, and the pad drive / status outputs.
interface pad_share_ctrl_if #(
  parameter int PADS = 4
);
  logic                cfg_cs_n;
  logic                cfg_sck;
  logic                cfg_sdi;
  logic [4*PADS-1:0]   src_i;
  logic [PADS-1:0]     pad_o;
  logic [2*PADS-1:0]   sel_o;
  logic                busy_o;
  logic                cfg_err_o;

  modport master (
    output cfg_cs_n, cfg_sck, cfg_sdi, src_i,
    input  pad_o, sel_o, busy_o, cfg_err_o
  );

  modport slave (
    input  cfg_cs_n, cfg_sck, cfg_sdi, src_i,
    output pad_o, sel_o, busy_o, cfg_err_o
  );
endinterface

// File: rtl/pad_share_ctrl.sv
// Shared output pad controller: serially loaded 2-bit-per-pad source selection,
// applied only after a guard interval during which every pad is held low.
module pad_share_ctrl #(
  parameter int PADS      = 4,
  parameter int GUARD_CYC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  pad_share_ctrl_if.slave   bus
);
  localparam int SW    = 2 * PADS;
  localparam int CNT_W = $clog2(SW + 2);
  localparam int GC_W  = $clog2(GUARD_CYC + 1);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SW);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(SW + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [GC_W-1:0]  GC_LOAD  = GC_W'(GUARD_CYC);
  localparam logic [GC_W-1:0]  GC_ONE   = GC_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GUARD = 2'd2
  } state_t;

  // Pad inputs are asynchronous: two sync flops, then one more for edge detect.
  logic [1:0] cs_sync_q;
  logic [1:0] sck_sync_q;
  logic [1:0] sdi_sync_q;
  logic       cs_prev_q;
  logic       sck_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync_q  <= 2'b11;
      sck_sync_q <= 2'b00;
      sdi_sync_q <= 2'b00;
      cs_prev_q  <= 1'b1;
      sck_prev_q <= 1'b0;
    end else begin
      cs_sync_q  <= {cs_sync_q[0],  bus.cfg_cs_n};
      sck_sync_q <= {sck_sync_q[0], bus.cfg_sck};
      sdi_sync_q <= {sdi_sync_q[0], bus.cfg_sdi};
      cs_prev_q  <= cs_sync_q[1];
      sck_prev_q <= sck_sync_q[1];
    end
  end

  logic cs_n_s;
  logic sck_s;
  logic sdi_s;
  logic cs_rise;
  logic cs_fall;
  logic sck_rise;

  assign cs_n_s   = cs_sync_q[1];
  assign sck_s    = sck_sync_q[1];
  assign sdi_s    = sdi_sync_q[1];
  assign cs_rise  = cs_n_s & ~cs_prev_q;
  assign cs_fall  = ~cs_n_s & cs_prev_q;
  assign sck_rise = sck_s & ~sck_prev_q;

  state_t            state_q,   state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [SW-1:0]     shadow_q,  shadow_d;
  logic [GC_W-1:0]   guard_q,   guard_d;
  logic [SW-1:0]     sel_q,     sel_d;
  logic              err_q,     err_d;
  logic [PADS-1:0]   pad_q,     pad_d;

  // Per-pad 4:1 source mux driven by the applied selection.
  logic [PADS-1:0] pad_mux;

  for (genvar gi = 0; gi < PADS; gi++) begin : g_mux
    logic [3:0] cand;
    assign cand        = bus.src_i[gi*4 +: 4];
    assign pad_mux[gi] = cand[sel_q[2*gi +: 2]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shadow_q  <= '0;
      guard_q   <= '0;
      sel_q     <= '0;
      err_q     <= 1'b0;
      pad_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shadow_q  <= shadow_d;
      guard_q   <= guard_d;
      sel_q     <= sel_d;
      err_q     <= err_d;
      pad_q     <= pad_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shadow_d  = shadow_q;
    guard_d   = guard_q;
    sel_d     = sel_q;
    err_d     = err_q;
    pad_d     = pad_mux;

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          bit_cnt_d = '0;
          shadow_d  = '0;
          state_d   = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        // Frame end wins over a coincident sck edge.
        if (cs_rise) begin
          state_d = ST_IDLE;
          if (bit_cnt_q != CNT_FULL) begin
            err_d = 1'b1;
          end else begin
            err_d = 1'b0;
            if (shadow_q != sel_q) begin
              guard_d = GC_LOAD;
              state_d = ST_GUARD;
            end
          end
        end else if (sck_rise) begin
          shadow_d = {shadow_q[SW-2:0], sdi_s};
          if (bit_cnt_q != CNT_SAT) begin
            bit_cnt_d = bit_cnt_q + CNT_ONE;
          end
        end
      end

      ST_GUARD: begin
        // All pads low; frame starts seen here are deliberately dropped.
        pad_d   = '0;
        guard_d = guard_q - GC_ONE;
        if (guard_q == GC_ONE) begin
          sel_d   = shadow_q;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.pad_o     = pad_q;
  assign bus.sel_o     = sel_q;
  assign bus.busy_o    = (state_q == ST_GUARD);
  assign bus.cfg_err_o = err_q;

endmodule

// File: doc/pad_share_ctrl.md
# pad_share_ctrl

Shared-output-pad controller for the pulpino pad ring. It time-safely reassigns a small set of output pads (`PADS`) among four candidate core sources each, so that debug, UART and GPIO functions can reuse the same physical pads. The configuration is loaded through a 3-wire serial port driven from input pads. Every source change is preceded by a guard interval with the affected pads held low, so no glitch from a mixed old/new source reaches a pad.

## Interface
- `PADS`, 4, number of shared output pads (1..8)
- `GUARD_CYC`, 4, guard-interval length in clk cycles (>=1)

- `clk`  in  1  core clock (from clock pad)
- `rst_n`  in  1  asynchronous, active-low reset
- `cfg_cs_n`  in  1  config frame select, active low; asynchronous pad input
- `cfg_sck`  in  1  config shift clock; asynchronous pad input, sampled by clk
- `cfg_sdi`  in  1  config serial data; asynchronous pad input
- `src_i`  in  4*PADS  candidate sources; source s for pad p at bit p*4+s
- `pad_o`  out  PADS  registered drive to output pads
- `sel_o`  out  2*PADS  applied selection; pad p uses `sel_o[2p+1:2p]`
- `busy_o`  out  1  high while the FSM is in GUARD
- `cfg_err_o`  out  1  sticky frame-error flag

## Operation
**Input synchronization**
- `cfg_cs_n`, `cfg_sck` and `cfg_sdi` each pass through a 2-flop synchronizer.
- Reset values are 1, 0 and 0 respectively.
- A third flop on the synchronized cs_n and sck gives edge detection.
- All decisions below use the synchronized signals (`_s`).

**FSM states: IDLE, SHIFT, GUARD**
- **IDLE**
  - `pad_o` follows the mux of `sel_o`.
  - On a cs_n_s falling edge: clear the bit counter and the shadow register, then go to SHIFT.
- **SHIFT**
  - On each sck_s rising edge, shift sdi_s into a 2*PADS-bit shadow register, MSB first. The first bit received ends up in shadow[2*PADS-1].
  - The bit counter saturates at 2*PADS+1.
  - On a cs_n_s rising edge, one of three outcomes:
    - count != 2*PADS: set `cfg_err_o`, leave `sel_o` unchanged, go to IDLE.
    - count == 2*PADS and shadow == `sel_o`: clear `cfg_err_o`, go to IDLE with no guard.
    - count == 2*PADS and shadow != `sel_o`: clear `cfg_err_o`, load the guard counter with GUARD_CYC, go to GUARD.
  - If an sck_s rising edge and a cs_n_s rising edge occur in the same cycle, the sck edge is ignored.
- **GUARD**
  - All `pad_o` bits are driven 0.
  - Decrement the guard counter. In the last cycle, `sel_o <= shadow`; next state is IDLE.
  - cs_n_s falling edges during GUARD are dropped. They do not start a frame and do not set the error flag.
- The guard applies to all pads, including pads whose selection is unchanged.

**Reset**
- Resets `sel_o`=0 (every pad on source 0), `pad_o`=0, `busy_o`=0, `cfg_err_o`=0, state IDLE, counters and shadow 0.
- Reset during SHIFT or GUARD aborts the frame; the register values above apply immediately.

## Timing
- Pad-level to FSM latency is 2 clk for synchronization plus 1 clk for edge detection.
- An sck high time of at least 3 clk cycles and a low time of at least 3 clk cycles are required for reliable sampling.
- `pad_o(n+1)` = 0 if state(n)==GUARD, else mux(`sel_o`(n), `src_i`(n)). This gives 1-cycle latency from source to pad.
- Valid cs_n_s rise detected in cycle c (new config differs):
  - `busy_o` is high in cycles c+1 .. c+GUARD_CYC.
  - `pad_o` is 0 in cycles c+2 .. c+GUARD_CYC+1.
  - `sel_o` shows the new value from c+GUARD_CYC+1.
  - `pad_o` shows the new sources from c+GUARD_CYC+2.
- Identical config: no `busy_o` pulse and no `pad_o` disturbance.
- `cfg_err_o` updates in the cycle after the cs_n_s rise is detected.

## Test plan
- **Reset:** assert `rst_n`=0 mid-operation, then release → `pad_o`=0, `sel_o`=0, `busy_o`=0, `cfg_err_o`=0. With `src_i`=16'h0001 the next cycles give `pad_o`=4'b0001.
- **Valid frame:** PADS=4, send bits 1,1,1,0,0,1,0,0 (8'hE4) → `sel_o`=8'hE4 and `busy_o` high for exactly 4 cycles. `pad_o` is 0 for 4 cycles, then pad3 follows src3, pad2 follows src2, pad1 follows src1, pad0 follows src0.
- **Short and long frames:** a 7-bit frame, then a 9-bit frame → `cfg_err_o`=1 after each, `sel_o` unchanged, no guard. A following valid frame clears `cfg_err_o`.
- **Identical frame:** resend the current `sel_o` → `busy_o` never asserts, `pad_o` continues toggling with its sources without a gap, `cfg_err_o` is cleared.
- **Frame during GUARD:** start a second frame (8'h1B) while `busy_o`=1 → that frame is ignored and `sel_o` ends at the first frame's value. A frame started after `busy_o` falls applies 8'h1B.
- **Simultaneous edges:** sck and cs_n rise on the same clk at the 9th bit → the 9th bit is not shifted, the frame counts 8 bits and is accepted.
